// File: rtl/ife_vote_commit_unit.sv
// Lockstep result voter: collects per-core register sets, compares every core
// against core 0 a chunk at a time, and reports a verdict with a release handshake.
module ife_vote_commit_unit #(
  parameter int NUM_CORES      = 2,
  parameter int NUM_REGS       = 32,
  parameter int REG_WIDTH      = 64,
  parameter int BLOCK_ID_WIDTH = 8,
  parameter int REGS_PER_CYCLE = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_CORES-1:0]                    res_valid,
  output logic [NUM_CORES-1:0]                    res_ready,
  input  logic [NUM_CORES*BLOCK_ID_WIDTH-1:0]     res_block_id,
  input  logic [NUM_CORES*NUM_REGS*REG_WIDTH-1:0] res_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    out_ok,
  output logic                                    out_fail,
  output logic                                    reexecute_serial,
  output logic                                    out_timeout,
  output logic                                    out_id_err,
  output logic [BLOCK_ID_WIDTH-1:0]               out_block_id,
  output logic [NUM_CORES-1:0]                    mismatch_mask,
  output logic [$clog2(NUM_REGS)-1:0]             first_bad_reg,
  output logic [7:0]                              fail_count
);

  localparam int NUM_CHUNKS = NUM_REGS / REGS_PER_CYCLE;
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int REG_IDX_W  = $clog2(NUM_REGS);
  localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, REPORT} state_t;

  state_t                      state, state_next;
  logic [NUM_CORES-1:0]        arrived, arrived_next, new_arr;
  logic [BLOCK_ID_WIDTH-1:0]   tags [NUM_CORES];
  logic [TMO_W-1:0]            tmo_cnt;
  logic [CHUNK_W-1:0]          chunk_cnt;
  logic [NUM_CORES-1:0]        rep_mask;
  logic [REG_IDX_W-1:0]        rep_first;
  logic                        found;
  logic                        timeout_q;
  logic                        id_err_q;
  logic                        verdict_bad;

  logic [NUM_CORES-1:0]        tag_mask;
  logic                        tag_check_fail;
  logic [NUM_CORES-1:0]        chunk_mask;
  logic                        chunk_hit;
  logic [REG_IDX_W-1:0]        chunk_first;
  int                          base;

  always_comb begin
    tag_mask = '0;
    for (int c = 1; c < NUM_CORES; c++) begin
      tag_mask[c] = (tags[c] != tags[0]);
    end
    tag_check_fail = (chunk_cnt == '0) && (|tag_mask);
  end

  // Descending register order so the lowest mismatching index in the chunk wins.
  always_comb begin
    chunk_mask  = '0;
    chunk_hit   = 1'b0;
    chunk_first = '0;
    base        = int'(chunk_cnt) * REGS_PER_CYCLE;
    for (int j = REGS_PER_CYCLE - 1; j >= 0; j--) begin
      for (int c = 1; c < NUM_CORES; c++) begin
        if (res_data[(c*NUM_REGS + base + j)*REG_WIDTH +: REG_WIDTH] !=
            res_data[(base + j)*REG_WIDTH +: REG_WIDTH]) begin
          chunk_mask[c] = 1'b1;
          chunk_hit     = 1'b1;
          chunk_first   = REG_IDX_W'(base + j);
        end
      end
    end
  end

  // A core whose release pulse is in flight still shows res_valid this cycle;
  // it must not be counted as a fresh arrival.
  always_comb begin
    state_next = state;
    new_arr    = '0;
    if (state == IDLE || state == COLLECT) begin
      new_arr = res_valid & ~arrived & ~res_ready;
    end
    arrived_next = arrived | new_arr;
    case (state)
      IDLE: begin
        if (|new_arr) state_next = (&arrived_next) ? COMPARE : COLLECT;
      end
      COLLECT: begin
        if (&arrived_next) state_next = COMPARE;
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) state_next = REPORT;
      end
      COMPARE: begin
        if (tag_check_fail || chunk_cnt == CHUNK_W'(NUM_CHUNKS - 1)) state_next = REPORT;
      end
      REPORT: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arrived    <= '0;
      for (int c = 0; c < NUM_CORES; c++) tags[c] <= '0;
      tmo_cnt    <= '0;
      chunk_cnt  <= '0;
      rep_mask   <= '0;
      rep_first  <= '0;
      found      <= 1'b0;
      timeout_q  <= 1'b0;
      id_err_q   <= 1'b0;
      out_valid  <= 1'b0;
      res_ready  <= '0;
      fail_count <= '0;
    end else begin
      res_ready <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (new_arr[c]) tags[c] <= res_block_id[c*BLOCK_ID_WIDTH +: BLOCK_ID_WIDTH];
      end
      case (state)
        IDLE: begin
          arrived   <= arrived_next;
          tmo_cnt   <= '0;
          chunk_cnt <= '0;
          rep_mask  <= '0;
          rep_first <= '0;
          found     <= 1'b0;
          timeout_q <= 1'b0;
          id_err_q  <= 1'b0;
        end
        COLLECT: begin
          arrived <= arrived_next;
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (state_next == REPORT) begin
            timeout_q <= 1'b1;
            out_valid <= 1'b1;
          end
        end
        COMPARE: begin
          chunk_cnt <= chunk_cnt + CHUNK_W'(1);
          if (tag_check_fail) begin
            rep_mask <= tag_mask;
            id_err_q <= 1'b1;
          end else begin
            rep_mask <= rep_mask | chunk_mask;
            if (chunk_hit && !found) begin
              found     <= 1'b1;
              rep_first <= chunk_first;
            end
          end
          if (state_next == REPORT) out_valid <= 1'b1;
        end
        REPORT: begin
          if (out_ready) begin
            res_ready <= arrived;
            arrived   <= '0;
            for (int c = 0; c < NUM_CORES; c++) tags[c] <= '0;
            out_valid <= 1'b0;
            rep_mask  <= '0;
            rep_first <= '0;
            found     <= 1'b0;
            timeout_q <= 1'b0;
            id_err_q  <= 1'b0;
            if (!verdict_bad)            fail_count <= '0;
            else if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign verdict_bad      = (|rep_mask) | timeout_q | id_err_q;
  assign out_ok           = out_valid & ~verdict_bad;
  assign out_fail         = out_valid & verdict_bad;
  assign reexecute_serial = out_fail;
  assign out_timeout      = out_valid & timeout_q;
  assign out_id_err       = out_valid & id_err_q;
  assign out_block_id     = out_valid ? tags[0] : '0;
  assign mismatch_mask    = out_valid ? rep_mask : '0;
  assign first_bad_reg    = out_valid ? rep_first : '0;

endmodule

// File: tb/tb_ife_vote_commit_unit.sv
// Directed bench for ife_vote_commit_unit: default 2-core instance plus a
// 3-core instance comparing 8 registers per cycle.
module tb_ife_vote_commit_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]    valid_a, ready_a;
  logic [15:0]   id_a;
  logic [4095:0] data_a;
  logic          out_ready_a, ov_a, ok_a, fail_a, rex_a, tmo_a, iderr_a;
  logic [7:0]    bid_a, fc_a;
  logic [1:0]    mask_a;
  logic [4:0]    bad_a;

  logic [2:0]    valid_b, ready_b;
  logic [23:0]   id_b;
  logic [6143:0] data_b;
  logic          out_ready_b, ov_b, ok_b, fail_b, rex_b, tmo_b, iderr_b;
  logic [7:0]    bid_b, fc_b;
  logic [2:0]    mask_b;
  logic [4:0]    bad_b;

  int passed = 0;
  int total  = 0;

  ife_vote_commit_unit dut_a (
    .clk(clk), .rst_n(rst_n),
    .res_valid(valid_a), .res_ready(ready_a), .res_block_id(id_a), .res_data(data_a),
    .out_valid(ov_a), .out_ready(out_ready_a), .out_ok(ok_a), .out_fail(fail_a),
    .reexecute_serial(rex_a), .out_timeout(tmo_a), .out_id_err(iderr_a),
    .out_block_id(bid_a), .mismatch_mask(mask_a), .first_bad_reg(bad_a), .fail_count(fc_a)
  );

  ife_vote_commit_unit #(.NUM_CORES(3), .REGS_PER_CYCLE(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .res_valid(valid_b), .res_ready(ready_b), .res_block_id(id_b), .res_data(data_b),
    .out_valid(ov_b), .out_ready(out_ready_b), .out_ok(ok_b), .out_fail(fail_b),
    .reexecute_serial(rex_b), .out_timeout(tmo_b), .out_id_err(iderr_b),
    .out_block_id(bid_b), .mismatch_mask(mask_b), .first_bad_reg(bad_b), .fail_count(fc_b)
  );

  function automatic logic [63:0] pattern(input int r);
    return 64'h0123_4567_89AB_CDEF ^ {32'(r), 32'(r * 7 + 1)};
  endfunction

  task automatic fill_a();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++) data_a[(c*32 + r)*64 +: 64] = pattern(r);
  endtask

  task automatic fill_b();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 32; r++) data_b[(c*32 + r)*64 +: 64] = pattern(r);
  endtask

  // n = edges after the arrival edge until out_valid is seen (capped)
  task automatic wait_valid_a(input int cap, output int n);
    @(posedge clk); #1;
    n = 0;
    while (!ov_a && n < cap) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_valid_b(input int cap, output int n);
    @(posedge clk); #1;
    n = 0;
    while (!ov_b && n < cap) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic start_a(input logic [7:0] t0, input logic [7:0] t1, input logic [1:0] v,
                         input int cap, output int n);
    id_a    = {t1, t0};
    valid_a = v;
    wait_valid_a(cap, n);
  endtask

  task automatic finish_a(output logic [1:0] pulse, output logic ov_after, output logic [1:0] after);
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    pulse       = ready_a;
    ov_after    = ov_a;
    out_ready_a = 1'b0;
    valid_a     = valid_a & ~ready_a;
    @(posedge clk); #1;
    after = ready_a;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if ({ov_a, ready_a, ok_a, fail_a, rex_a, tmo_a, iderr_a} !== 9'b0)
      $display("[TB] FAIL reset_flags_a: got %b expected 0", {ov_a, ready_a, ok_a, fail_a, rex_a, tmo_a, iderr_a});
    else passed++;
    total++;
    if ({bid_a, mask_a, bad_a, fc_a} !== 23'b0)
      $display("[TB] FAIL reset_fields_a: got %h expected 0", {bid_a, mask_a, bad_a, fc_a});
    else passed++;
    total++;
    if ({ov_b, ready_b, ok_b, fail_b, mask_b, bad_b, fc_b} !== 23'b0)
      $display("[TB] FAIL reset_b: got %h expected 0", {ov_b, ready_b, ok_b, fail_b, mask_b, bad_b, fc_b});
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_ok();
    int n;
    logic [1:0] p, a;
    logic o;
    fill_a();
    start_a(8'h12, 8'h12, 2'b11, 600, n);
    total++;
    if (n !== 8) $display("[TB] FAIL ok_latency: got %0d expected 8", n); else passed++;
    total++;
    if ({ok_a, fail_a, rex_a, mask_a} !== 5'b10000)
      $display("[TB] FAIL ok_flags: got %b expected 10000", {ok_a, fail_a, rex_a, mask_a});
    else passed++;
    total++;
    if (bid_a !== 8'h12) $display("[TB] FAIL ok_block_id: got %h expected 12", bid_a); else passed++;
    finish_a(p, o, a);
    total++;
    if (p !== 2'b11) $display("[TB] FAIL ok_release: got %b expected 11", p); else passed++;
    total++;
    if ({o, ok_a, fail_a} !== 3'b000) $display("[TB] FAIL ok_clear: got %b expected 000", {o, ok_a, fail_a}); else passed++;
    total++;
    if (a !== 2'b00) $display("[TB] FAIL ok_pulse_len: got %b expected 00", a); else passed++;
    total++;
    if (fc_a !== 8'd0) $display("[TB] FAIL ok_fail_count: got %0d expected 0", fc_a); else passed++;
  endtask

  task automatic test_mismatch();
    int ra [3];
    int ba [3];
    int rb [3];
    int bb [3];
    int n;
    logic [1:0] p, a;
    logic o;
    ra = '{13, 5, 31};
    ba = '{0, 17, 63};
    rb = '{30, 7, 31};
    bb = '{40, 2, 63};
    for (int i = 0; i < 3; i++) begin
      fill_a();
      data_a[(32 + ra[i])*64 + ba[i]] = ~data_a[(32 + ra[i])*64 + ba[i]];
      if (rb[i] != ra[i]) data_a[(32 + rb[i])*64 + bb[i]] = ~data_a[(32 + rb[i])*64 + bb[i]];
      start_a(8'h21, 8'h21, 2'b11, 600, n);
      total++;
      if (n !== 8) $display("[TB] FAIL mm%0d_latency: got %0d expected 8", i, n); else passed++;
      total++;
      if ({ok_a, fail_a, rex_a, mask_a} !== 5'b01110)
        $display("[TB] FAIL mm%0d_flags: got %b expected 01110", i, {ok_a, fail_a, rex_a, mask_a});
      else passed++;
      total++;
      if (bad_a !== 5'(ra[i])) $display("[TB] FAIL mm%0d_first_bad: got %0d expected %0d", i, bad_a, ra[i]); else passed++;
      finish_a(p, o, a);
      total++;
      if (p !== 2'b11) $display("[TB] FAIL mm%0d_release: got %b expected 11", i, p); else passed++;
      total++;
      if (fc_a !== 8'(i + 1)) $display("[TB] FAIL mm%0d_fail_count: got %0d expected %0d", i, fc_a, i + 1); else passed++;
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [1:0] p, a;
    logic o;
    fill_a();
    start_a(8'h33, 8'h44, 2'b01, 600, n);
    total++;
    if (n !== 256) $display("[TB] FAIL tmo_latency: got %0d expected 256", n); else passed++;
    total++;
    if ({tmo_a, fail_a, ok_a, iderr_a} !== 4'b1100)
      $display("[TB] FAIL tmo_flags: got %b expected 1100", {tmo_a, fail_a, ok_a, iderr_a});
    else passed++;
    finish_a(p, o, a);
    total++;
    if (p !== 2'b01) $display("[TB] FAIL tmo_release: got %b expected 01", p); else passed++;
    total++;
    if (fc_a !== 8'd4) $display("[TB] FAIL tmo_fail_count: got %0d expected 4", fc_a); else passed++;
  endtask

  task automatic test_id_err();
    int n;
    logic [1:0] p, a;
    logic o;
    fill_a();
    start_a(8'h05, 8'h06, 2'b11, 600, n);
    total++;
    if (n !== 1) $display("[TB] FAIL id_latency: got %0d expected 1", n); else passed++;
    total++;
    if ({iderr_a, fail_a, ok_a, tmo_a, mask_a} !== 6'b110010)
      $display("[TB] FAIL id_flags: got %b expected 110010", {iderr_a, fail_a, ok_a, tmo_a, mask_a});
    else passed++;
    total++;
    if (bid_a !== 8'h05) $display("[TB] FAIL id_block_id: got %h expected 05", bid_a); else passed++;
    finish_a(p, o, a);
    total++;
    if (p !== 2'b11) $display("[TB] FAIL id_release: got %b expected 11", p); else passed++;
  endtask

  task automatic test_three_cores();
    int n;
    fill_b();
    data_b[(2*32 + 0)*64 + 5] = ~data_b[(2*32 + 0)*64 + 5];
    id_b    = {3{8'h77}};
    valid_b = 3'b111;
    wait_valid_b(600, n);
    total++;
    if (n !== 4) $display("[TB] FAIL c3_latency: got %0d expected 4", n); else passed++;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++;
      if ({ov_b, fail_b, ok_b, mask_b, bad_b, bid_b, ready_b} !== {3'b110, 3'b100, 5'd0, 8'h77, 3'b000})
        $display("[TB] FAIL c3_hold%0d: got %h expected %h", k, {ov_b, fail_b, ok_b, mask_b, bad_b, bid_b, ready_b},
                 {3'b110, 3'b100, 5'd0, 8'h77, 3'b000});
      else passed++;
    end
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ready_b, ov_b} !== 4'b1110) $display("[TB] FAIL c3_release: got %b expected 1110", {ready_b, ov_b}); else passed++;
    out_ready_b = 1'b0;
    valid_b     = 3'b000;
    total++;
    if (fc_b !== 8'd1) $display("[TB] FAIL c3_fail_count: got %0d expected 1", fc_b); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [1:0] p, a;
    logic o;
    fill_a();
    id_a    = {8'h12, 8'h12};
    valid_a = 2'b11;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({ov_a, ready_a, ok_a, fail_a, rex_a, tmo_a, iderr_a, bid_a, mask_a, bad_a} !== 24'b0)
      $display("[TB] FAIL rstmid_outputs: got %h expected 0", {ov_a, ready_a, ok_a, fail_a, rex_a, tmo_a, iderr_a, bid_a, mask_a, bad_a});
    else passed++;
    total++;
    if (fc_a !== 8'd0) $display("[TB] FAIL rstmid_fail_count: got %0d expected 0", fc_a); else passed++;
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if (ready_a !== 2'b00) $display("[TB] FAIL rstmid_no_release: got %b expected 00", ready_a); else passed++;
    end
    rst_n = 1'b1;
    wait_valid_a(600, n);
    total++;
    if ({n == 8, ok_a} !== 2'b11) $display("[TB] FAIL rstmid_redo: got latency %0d ok %b expected 8 1", n, ok_a); else passed++;
    finish_a(p, o, a);
    total++;
    if ({p, a} !== 4'b1100) $display("[TB] FAIL rstmid_release: got %b expected 1100", {p, a}); else passed++;
  endtask

  task automatic test_fail_saturation();
    int n;
    logic [1:0] p, a;
    logic o;
    fill_a();
    for (int i = 0; i < 256; i++) begin
      start_a(8'h01, 8'h02, 2'b11, 600, n);
      finish_a(p, o, a);
    end
    total++;
    if (fc_a !== 8'd255) $display("[TB] FAIL sat_fail_count: got %0d expected 255", fc_a); else passed++;
    start_a(8'h09, 8'h09, 2'b11, 600, n);
    finish_a(p, o, a);
    total++;
    if (fc_a !== 8'd0) $display("[TB] FAIL sat_clear: got %0d expected 0", fc_a); else passed++;
  endtask

  initial begin
    rst_n       = 1'b0;
    valid_a     = '0;
    valid_b     = '0;
    id_a        = '0;
    id_b        = '0;
    data_a      = '0;
    data_b      = '0;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
    test_reset();
    test_ok();
    test_mismatch();
    test_timeout();
    test_id_err();
    test_three_cores();
    test_reset_mid();
    test_fail_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
